// File: rtl/seq_period_monitor.sv
// Period monitor for a W-bit sequence generator: learns one period of the code stream,
// then tracks it, flagging mismatches, period overflow and a stuck generator.
module seq_period_monitor #(
  parameter int W         = 4,
  parameter int MAXP      = 16,
  parameter int STUCK_LIM = 4,
  parameter int ERRW      = 8
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        en,
  input  logic [W-1:0]                code,
  output logic                        locked,
  output logic [$clog2(MAXP+1)-1:0]   period,
  output logic                        seq_err,
  output logic                        stuck,
  output logic [ERRW-1:0]             err_cnt
);

  localparam int PW = $clog2(MAXP + 1);
  localparam int AW = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int RW = $clog2(STUCK_LIM + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEARN = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   p, p_nxt, pos, pos_nxt, period_nxt;
  logic            locked_nxt, err_hit;
  logic [ERRW-1:0] err_cnt_nxt;
  logic [W-1:0]    mem [MAXP];
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [W-1:0]    prev;
  logic [RW-1:0]   rep, rep_nxt;
  logic            stuck_nxt;

  // Next-state, pattern-memory write and error decode for the learn/track FSM
  always_comb begin
    state_nxt  = state;
    p_nxt      = p;
    pos_nxt    = pos;
    locked_nxt = locked;
    period_nxt = period;
    err_hit    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {AW{1'b0}};
    if (en) begin
      case (state)
        IDLE: begin
          mem_we    = 1'b1;
          p_nxt     = PW'(1);
          state_nxt = LEARN;
        end
        LEARN: begin
          if (code == mem[AW'(0)]) begin
            period_nxt = p;
            locked_nxt = 1'b1;
            pos_nxt    = (p == PW'(1)) ? {PW{1'b0}} : PW'(1);
            state_nxt  = TRACK;
          end else if (p == PW'(MAXP)) begin
            err_hit   = 1'b1;
            state_nxt = IDLE;
          end else begin
            mem_we   = 1'b1;
            mem_addr = p[AW-1:0];
            p_nxt    = p + PW'(1);
          end
        end
        TRACK: begin
          if (code == mem[pos[AW-1:0]]) begin
            pos_nxt = (pos + PW'(1) == period) ? {PW{1'b0}} : pos + PW'(1);
          end else begin
            // Mismatching sample becomes the first entry of the next period
            err_hit    = 1'b1;
            locked_nxt = 1'b0;
            period_nxt = {PW{1'b0}};
            mem_we     = 1'b1;
            p_nxt      = PW'(1);
            state_nxt  = LEARN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else begin
      state_nxt = state;
    end

    if (err_hit && (err_cnt != {ERRW{1'b1}})) begin
      err_cnt_nxt = err_cnt + ERRW'(1);
    end else begin
      err_cnt_nxt = err_cnt;
    end

    // rep == 0 means no sample seen since reset
    if (en && (rep != {RW{1'b0}}) && (code == prev)) begin
      rep_nxt = (rep == RW'(STUCK_LIM)) ? rep : rep + RW'(1);
    end else if (en) begin
      rep_nxt = RW'(1);
    end else begin
      rep_nxt = rep;
    end
    stuck_nxt = (rep_nxt >= RW'(STUCK_LIM));
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= IDLE;
      p       <= {PW{1'b0}};
      pos     <= {PW{1'b0}};
      locked  <= 1'b0;
      period  <= {PW{1'b0}};
      seq_err <= 1'b0;
      err_cnt <= {ERRW{1'b0}};
      prev    <= {W{1'b0}};
      rep     <= {RW{1'b0}};
      stuck   <= 1'b0;
    end else begin
      state   <= state_nxt;
      p       <= p_nxt;
      pos     <= pos_nxt;
      locked  <= locked_nxt;
      period  <= period_nxt;
      seq_err <= err_hit;
      err_cnt <= err_cnt_nxt;
      prev    <= en ? code : prev;
      rep     <= rep_nxt;
      stuck   <= stuck_nxt;
    end
  end

  // Pattern memory; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (clr && mem_we) begin
      mem[mem_addr] <= code;
    end else begin
      mem[mem_addr] <= mem[mem_addr];
    end
  end

endmodule

// File: tb/tb_seq_period_monitor.sv
// Directed self-checking bench for seq_period_monitor; a second instance with ERRW=2
// shares the stimulus to exercise error-counter saturation.
module tb_seq_period_monitor;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [3:0] code = 4'h0;
  logic       locked, seq_err, stuck;
  logic [4:0] period;
  logic [7:0] err_cnt;
  logic       locked2, seq_err2, stuck2;
  logic [4:0] period2;
  logic [1:0] err_cnt2;
  int errors = 0;
  int checks = 0;

  seq_period_monitor dut (
    .clk(clk), .clr(clr), .en(en), .code(code), .locked(locked), .period(period),
    .seq_err(seq_err), .stuck(stuck), .err_cnt(err_cnt)
  );

  seq_period_monitor #(.ERRW(2)) dut2 (
    .clk(clk), .clr(clr), .en(en), .code(code), .locked(locked2), .period(period2),
    .seq_err(seq_err2), .stuck(stuck2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  task automatic step(input logic e, input logic [3:0] c);
    @(negedge clk);
    clr = 1'b1; en = e; code = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0; en = 1'b1; code = 4'hD;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0d want 0", locked); end
    checks++; if (period !== 5'd0) begin errors++; $display("FAIL reset_period got %0d want 0", period); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err got %0d want 0", seq_err); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck got %0d want 0", stuck); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
  endtask

  // Feeds 0,1,3,7,F,E,C,8,0, optionally with en=0 bubbles carrying junk codes
  task automatic learn_period8(input bit bubbles, input string tag);
    logic [3:0] seq [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    for (int i = 0; i < 9; i++) begin
      step(1'b1, seq[i]);
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL %s_seq_err sample %0d got %0d want 0", tag, i, seq_err); end
      if (i == 7) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL %s_early_lock got %0d want 0", tag, locked); end
      end
      if (bubbles) begin
        step(1'b0, 4'h5);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL %s_bubble_seq_err got %0d want 0", tag, seq_err); end
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL %s_locked got %0d want 1", tag, locked); end
    checks++; if (period !== 5'd8) begin errors++; $display("FAIL %s_period got %0d want 8", tag, period); end
  endtask

  task automatic test_learn();
    do_reset();
    learn_period8(1'b0, "learn");
  endtask

  task automatic test_mismatch();
    step(1'b1, 4'h1);
    step(1'b1, 4'h3);
    checks++; if (seq_err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL mm_track got err=%0d lock=%0d want 0/1", seq_err, locked); end
    step(1'b1, 4'h5);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL mm_seq_err got %0d want 1", seq_err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mm_err_cnt got %0d want 1", err_cnt); end
    checks++; if (locked !== 1'b0 || period !== 5'd0) begin errors++; $display("FAIL mm_unlock got lock=%0d period=%0d want 0/0", locked, period); end
    step(1'b1, 4'h5);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL mm_pulse_len got %0d want 0", seq_err); end
    checks++; if (locked !== 1'b1 || period !== 5'd1) begin errors++; $display("FAIL mm_relearn got lock=%0d period=%0d want 1/1", locked, period); end
    step(1'b1, 4'h5);
    step(1'b1, 4'h5);
    checks++; if (stuck !== 1'b1 || seq_err !== 1'b0) begin errors++; $display("FAIL mm_stuck got stuck=%0d err=%0d want 1/0", stuck, seq_err); end
  endtask

  task automatic test_stuck();
    do_reset();
    step(1'b1, 4'hA);
    checks++; if (locked !== 1'b0 || stuck !== 1'b0) begin errors++; $display("FAIL st_a1 got lock=%0d stuck=%0d want 0/0", locked, stuck); end
    step(1'b1, 4'hA);
    checks++; if (locked !== 1'b1 || period !== 5'd1) begin errors++; $display("FAIL st_lock1 got lock=%0d period=%0d want 1/1", locked, period); end
    step(1'b1, 4'hA);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL st_a3 got %0d want 0", stuck); end
    step(1'b1, 4'hA);
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL st_a4 got %0d want 1", stuck); end
    step(1'b1, 4'hA);
    checks++; if (stuck !== 1'b1 || seq_err !== 1'b0) begin errors++; $display("FAIL st_sat got stuck=%0d err=%0d want 1/0", stuck, seq_err); end
    step(1'b1, 4'hB);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL st_clear got %0d want 0", stuck); end
    checks++; if (seq_err !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL st_b_err got err=%0d lock=%0d want 1/0", seq_err, locked); end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1'b1, 4'h0);
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 4'(i));
      checks++; if (locked !== 1'b0 || seq_err !== 1'b0) begin errors++; $display("FAIL ov_fill %0d got lock=%0d err=%0d want 0/0", i, locked, seq_err); end
    end
    step(1'b1, 4'h1);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL ov_seq_err got %0d want 1", seq_err); end
    checks++; if (err_cnt !== 8'd1 || locked !== 1'b0) begin errors++; $display("FAIL ov_cnt got cnt=%0d lock=%0d want 1/0", err_cnt, locked); end
    step(1'b1, 4'h3);
    checks++; if (seq_err !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL ov_idle got err=%0d lock=%0d want 0/0", seq_err, locked); end
    step(1'b1, 4'h3);
    checks++; if (locked !== 1'b1 || period !== 5'd1) begin errors++; $display("FAIL ov_relock got lock=%0d period=%0d want 1/1", locked, period); end
  endtask

  task automatic test_bubbles_clr();
    do_reset();
    learn_period8(1'b1, "bub");
    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    step(1'b1, 4'h2);
    step(1'b1, 4'h2);
    step(1'b1, 4'h2);
    checks++; if (locked !== 1'b1 || stuck !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL bub_pre got lock=%0d stuck=%0d cnt=%0d want 1/1/1", locked, stuck, err_cnt); end
    do_reset();
    checks++; if (locked !== 1'b0 || period !== 5'd0 || seq_err !== 1'b0) begin errors++; $display("FAIL clr_fsm got lock=%0d period=%0d err=%0d want 0/0/0", locked, period, seq_err); end
    checks++; if (stuck !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got stuck=%0d cnt=%0d want 0/0", stuck, err_cnt); end
    step(1'b1, 4'h9);
    step(1'b1, 4'h9);
    checks++; if (locked !== 1'b1 || period !== 5'd1) begin errors++; $display("FAIL clr_relock got lock=%0d period=%0d want 1/1", locked, period); end
  endtask

  task automatic test_err_sat();
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    step(1'b1, 4'h5);
    step(1'b1, 4'h5);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(6 + i));
      checks++; if (seq_err !== 1'b1 || seq_err2 !== 1'b1) begin errors++; $display("FAIL sat_pulse %0d got %0d/%0d want 1/1", i, seq_err, seq_err2); end
      checks++; if (err_cnt2 !== exp2[i]) begin errors++; $display("FAIL sat_cnt2 %0d got %0d want %0d", i, err_cnt2, exp2[i]); end
      checks++; if (err_cnt !== 8'(i + 1)) begin errors++; $display("FAIL sat_cnt8 %0d got %0d want %0d", i, err_cnt, i + 1); end
      step(1'b1, 4'(6 + i));
      checks++; if (locked2 !== 1'b1 || seq_err2 !== 1'b0) begin errors++; $display("FAIL sat_relock %0d got lock=%0d err=%0d want 1/0", i, locked2, seq_err2); end
    end
  endtask

  initial begin
    test_reset();
    test_learn();
    test_mismatch();
    test_stuck();
    test_overflow();
    test_bubbles_clr();
    test_err_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
